readout_sequencer: RTL and testbench



---
 rtl/readout_sequencer.sv | 110 +++++++++++
 tb/tb_readout_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_sequencer.sv
// readout_sequencer: walks the readout byte map and hands each settled byte to the host link (optional FRAME_CHECKSUM_EN appends an XOR checksum byte)
module readout_sequencer #(
    parameter int LAST_ADDR     = 23,
    parameter int SKIP_ADDR     = 6,
    parameter int PARK_ADDR     = 31,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] addr,
    input  logic [7:0] rd_bus,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;
`ifdef FRAME_CHECKSUM_EN
    localparam logic [1:0] CKSUM  = 2'd3;
`endif
    localparam logic [4:0] LAST_A    = 5'(LAST_ADDR);
    localparam logic [4:0] SKIP_A    = 5'(SKIP_ADDR);
    localparam logic [4:0] PARK_A    = 5'(PARK_ADDR);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [4:0] inc;
    logic [4:0] next_addr;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] cksum;
`endif

    // next address in the map, stepping over the unmapped hole
    always_comb begin
        inc       = addr + 5'd1;
        next_addr = (inc == SKIP_A) ? inc + 5'd1 : inc;
    end

    // frame sequencing: settle, capture, hand off, advance or park
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr      <= PARK_A;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            cksum     <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    addr  <= 5'd0;
                    busy  <= 1'b1;
                    cnt   <= SETTLE_M1;
                    state <= SETTLE;
`ifdef FRAME_CHECKSUM_EN
                    cksum <= 8'd0;
`endif
                end
                SETTLE: if (cnt == 4'd0) begin
                    out_data  <= rd_bus;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                SEND: if (out_ready) begin
                    out_valid <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    cksum     <= cksum ^ out_data;
`endif
                    if (addr == LAST_A) begin
                        addr  <= PARK_A;
`ifdef FRAME_CHECKSUM_EN
                        out_data  <= cksum ^ out_data;
                        out_valid <= 1'b1;
                        state     <= CKSUM;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
`endif
                    end else begin
                        addr  <= next_addr;
                        cnt   <= SETTLE_M1;
                        state <= SETTLE;
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                CKSUM: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: randomized frame checks of readout_sequencer against a byte-map reference model
module tb_readout_sequencer;
    localparam int LAST = 23;
    localparam int SKIP = 6;
    localparam int PARK = 31;
    localparam int S    = 2;
`ifdef FRAME_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, out_valid, out_ready, busy, done;
    logic [4:0] addr;
    logic [7:0] rd_bus, out_data, lag_bus;
    logic [7:0] tbl [32];
    bit         lag_en;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_data [$];
    int         exp_addr [$];
    int         n_data;

    always #5 clk = ~clk;

    readout_sequencer #(
        .LAST_ADDR(LAST), .SKIP_ADDR(SKIP), .PARK_ADDR(PARK), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .rd_bus(rd_bus),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // bus source that only shows the newly selected byte one clock after the address moves
    always @(posedge clk) lag_bus <= tbl[addr];
    assign rd_bus = lag_en ? lag_bus : tbl[addr];

    function automatic bit legal(input logic [4:0] a);
        return (int'(a) <= LAST && int'(a) != SKIP) || int'(a) == PARK;
    endfunction

    task automatic fill(input bit rnd);
        for (int a = 0; a < 32; a++) tbl[a] = rnd ? 8'($urandom_range(0, 255)) : 8'(a);
    endtask

    // expected frame: every mapped address in order, plus optional XOR byte on the park address
    task automatic model_frame();
        logic [7:0] x;
        x = 8'd0;
        exp_data.delete();
        exp_addr.delete();
        for (int a = 0; a <= LAST; a++) begin
            if (a != SKIP) begin
                exp_addr.push_back(a);
                exp_data.push_back(tbl[a]);
                x ^= tbl[a];
            end
        end
        n_data = exp_data.size();
        if (CK == 1) begin
            exp_addr.push_back(PARK);
            exp_data.push_back(x);
        end
    endtask

    task automatic run_frame(input int pct, input int stall_addr, input int stall_len,
                             input int mid_addr, input bit prestarted, input bit timed);
        logic [7:0] got_d [$];
        int         got_a [$];
        int         n, dones, done_at, stall_left;
        bit         pv, pr, mid_done;
        logic [7:0] pd;
        logic [4:0] pa;
        n = 0; dones = 0; done_at = -1; stall_left = stall_len;
        pv = 0; pr = 0; mid_done = 0; pd = 8'd0; pa = 5'd0;
        model_frame();
        if (!prestarted) begin
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        while (dones == 0 && n < 3000) begin
            if (done === 1'b1) begin
                dones++;
                done_at = n;
            end
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || addr !== pa) begin
                    errors++;
                    $display("FAIL hold n=%0d valid=%b data=%h addr=%0d required valid=1 data=%h addr=%0d",
                             n, out_valid, out_data, addr, pd, pa);
                end
            end
            checks++;
            if (!legal(addr)) begin
                errors++;
                $display("FAIL addr_range n=%0d addr=%0d required a mapped or park address", n, addr);
            end
            checks++;
            if (busy !== (dones == 0)) begin
                errors++;
                $display("FAIL busy n=%0d busy=%b required %b", n, busy, dones == 0);
            end
            start = 1'b0;
            if (int'(addr) == mid_addr && !mid_done) begin
                start = 1'b1;
                mid_done = 1;
            end
            if (out_valid && int'(addr) == stall_addr && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < pct);
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_a.push_back(int'(addr));
            end
            pv = out_valid; pr = out_ready; pd = out_data; pa = addr;
            if (dones == 0) begin
                @(posedge clk); #1;
                n++;
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL done_seen dones=%0d required 1 within 3000 cycles", dones);
        end
        checks++;
        if (got_d.size() != exp_data.size()) begin
            errors++;
            $display("FAIL byte_count got=%0d required %0d", got_d.size(), exp_data.size());
        end else begin
            for (int i = 0; i < got_d.size(); i++) begin
                checks++;
                if (got_d[i] !== exp_data[i] || got_a[i] != exp_addr[i]) begin
                    errors++;
                    $display("FAIL byte[%0d] data=%h addr=%0d required data=%h addr=%0d",
                             i, got_d[i], got_a[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        if (timed) begin
            checks++;
            if (done_at != n_data * (S + 1) + CK) begin
                errors++;
                $display("FAIL frame_cycles got=%0d required %0d", done_at, n_data * (S + 1) + CK);
            end
        end
    endtask

    task automatic idle_check();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || addr !== 5'(PARK)) begin
                errors++;
                $display("FAIL idle done=%b busy=%b addr=%0d required 0 0 %0d", done, busy, addr, PARK);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (addr !== 5'(PARK) || out_data !== 8'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset addr=%0d data=%h valid=%b busy=%b done=%b required %0d 00 0 0 0",
                     addr, out_data, out_valid, busy, done, PARK);
        end
        rst = 1'b0;
    endtask

    task automatic test_identity_frame();
        fill(0);
        lag_en = 0;
        run_frame(100, -1, 0, -1, 0, 1);
        idle_check();
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        fill(0);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(out_valid && addr == 5'd9) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(out_valid && addr == 5'd9)) begin
            errors++;
            $display("FAIL reach_addr9 addr=%0d valid=%b required 9 1", addr, out_valid);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (addr !== 5'(PARK) || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid addr=%0d valid=%b busy=%b done=%b required %0d 0 0 0",
                     addr, out_valid, busy, done, PARK);
        end
        idle_check();
        run_frame(100, -1, 0, -1, 0, 1);
    endtask

    task automatic test_stall();
        fill(1);
        run_frame(100, 12, 10, -1, 0, 0);
        idle_check();
    endtask

    task automatic test_mid_start();
        fill(1);
        run_frame(100, -1, 0, 4, 0, 1);
        idle_check();
    endtask

    task automatic test_settle();
        fill(1);
        lag_en = 1;
        run_frame(70, -1, 0, -1, 0, 0);
        run_frame(100, -1, 0, -1, 0, 1);
        lag_en = 0;
        idle_check();
    endtask

    task automatic test_back_to_back();
        fill(0);
        run_frame(100, -1, 0, -1, 0, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || addr !== 5'd0) begin
            errors++;
            $display("FAIL back_to_back busy=%b addr=%0d required 1 0", busy, addr);
        end
        run_frame(100, -1, 0, -1, 1, 1);
        idle_check();
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            fill(1);
            lag_en = k[0];
            run_frame(30 + 20 * k, int'($urandom_range(0, LAST)), int'($urandom_range(1, 8)), -1, 0, 0);
        end
        lag_en = 0;
        idle_check();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        lag_en = 0;
        fill(0);
        test_reset();
        test_identity_frame();
        test_reset_mid();
        test_stall();
        test_mid_start();
        test_settle();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
